// File: rtl/io_port_arbiter.sv
// Round-robin arbiter that shares one single-access I/O block among NREQ requesters.
// Each grant runs one complete write or read transaction, then pulses ack for the winner.
module io_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [2*NREQ-1:0] req_port,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              io_we,
  output logic [1:0]        io_sel_port,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   pick_all;
  logic [GW-1:0]   pick_upper;
  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] upper_req;
  logic            found;
  logic            we_q;
  logic [CW-1:0]   cnt;
  logic            access_done;

  // Requesters above the last winner take precedence; otherwise wrap to the lowest index.
  always_comb begin
    upper_mask = '0;
    pick_all   = '0;
    pick_upper = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper_mask[i] = (i > int'(last_grant));
    end
    upper_req = req & upper_mask;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick_all = GW'(i);
      if (upper_req[i]) pick_upper = GW'(i);
    end
    found = |req;
    pick  = (|upper_req) ? pick_upper : pick_all;
  end

  // A read holds the port for RD_LAT cycles after the select settles, plus the settle cycle.
  assign access_done = we_q || (cnt == CW'(RD_LAT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      ack         <= '0;
      rdata       <= '0;
      io_we       <= 1'b0;
      io_sel_port <= '0;
      io_wdata    <= '0;
      last_grant  <= GW'(NREQ - 1);
      grant       <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= pick;
            we_q        <= req_we[pick];
            io_we       <= req_we[pick];
            io_sel_port <= req_port[int'(pick)*2 +: 2];
            io_wdata    <= req_wdata[int'(pick)*8 +: 8];
            cnt         <= '0;
          end
        end
        ACCESS: begin
          io_we <= 1'b0;
          if (!we_q) begin
            if (cnt == CW'(RD_LAT)) begin
              rdata <= io_rdata;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (access_done) begin
            ack[grant] <= 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant;
        end
        default: begin
          io_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
